fu_issue_ctrl: RTL and testbench

- Issue/retire sequencer for a multi-cycle functional unit.
- Accepts one operation from the issue stage and drives fu_go_o, which feeds the input of the ready_gen delay block.
- Consumes the ready_gen output as fu_done_i, captures the unit result and presents it to writeback with a valid/ack handshake.
- A watchdog converts a missing completion into an exception writeback; a flush aborts the operation at any point.

---
 rtl/fu_issue_ctrl.sv | 161 ++++++++++++++++
 tb/tb_fu_issue_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fu_issue_ctrl.sv
// Issue/retire sequencer for a multi-cycle functional unit: latches one operation,
// drives the ready_gen delay line, captures the result and hands it to writeback.
module fu_issue_ctrl #(
    parameter int unsigned DW   = 52,
    parameter int unsigned TAGW = 4,
    parameter int unsigned TMO  = 64,
    parameter int unsigned TMOW = 7
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            ce_i,
    input  logic            issue_v_i,
    output logic            issue_rdy_o,
    input  logic [TAGW-1:0] issue_tag_i,
    input  logic [3:0]      issue_op_i,
    input  logic [DW-1:0]   issue_a_i,
    input  logic [DW-1:0]   issue_b_i,
    output logic            fu_go_o,
    output logic [3:0]      fu_op_o,
    output logic [DW-1:0]   fu_a_o,
    output logic [DW-1:0]   fu_b_o,
    input  logic            fu_done_i,
    input  logic [DW-1:0]   fu_res_i,
    output logic            wb_v_o,
    output logic [TAGW-1:0] wb_tag_o,
    output logic [DW-1:0]   wb_res_o,
    output logic            wb_exc_o,
    input  logic            wb_ack_i,
    input  logic            flush_i
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_WB   = 2'd2;

    localparam logic [TMOW-1:0] CNT_LAST = TMOW'(TMO - 1);

    logic [1:0]      r_state;
    logic [TMOW-1:0] r_cnt;
    logic            r_go;
    logic [3:0]      r_op;
    logic [DW-1:0]   r_a;
    logic [DW-1:0]   r_b;
    logic            r_wb_v;
    logic [TAGW-1:0] r_wb_tag;
    logic [DW-1:0]   r_wb_res;
    logic            r_wb_exc;

    logic [1:0]      w_state;
    logic [TMOW-1:0] w_cnt;
    logic            w_go;
    logic [3:0]      w_op;
    logic [DW-1:0]   w_a;
    logic [DW-1:0]   w_b;
    logic            w_wb_v;
    logic [TAGW-1:0] w_wb_tag;
    logic [DW-1:0]   w_wb_res;
    logic            w_wb_exc;

    always_comb begin
        w_state  = r_state;
        w_cnt    = r_cnt;
        w_go     = r_go;
        w_op     = r_op;
        w_a      = r_a;
        w_b      = r_b;
        w_wb_v   = r_wb_v;
        w_wb_tag = r_wb_tag;
        w_wb_res = r_wb_res;
        w_wb_exc = r_wb_exc;

        if (ce_i) begin
            unique case (r_state)
                ST_IDLE: begin
                    if (issue_v_i) begin
                        w_op     = issue_op_i;
                        w_a      = issue_a_i;
                        w_b      = issue_b_i;
                        w_wb_tag = issue_tag_i;
                        w_go     = 1'b1;
                        w_cnt    = '0;
                        w_state  = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (flush_i) begin
                        w_go    = 1'b0;
                        w_state = ST_IDLE;
                    end else if (fu_done_i) begin
                        w_wb_res = fu_res_i;
                        w_wb_exc = 1'b0;
                        w_go     = 1'b0;
                        w_wb_v   = 1'b1;
                        w_state  = ST_WB;
                    end else if (r_cnt == CNT_LAST) begin
                        w_wb_res = '0;
                        w_wb_exc = 1'b1;
                        w_go     = 1'b0;
                        w_wb_v   = 1'b1;
                        w_state  = ST_WB;
                    end else begin
                        w_cnt = r_cnt + TMOW'(1);
                    end
                end
                ST_WB: begin
                    // fu_done_i is still high for one cycle here and must be ignored
                    if (flush_i) begin
                        w_wb_v  = 1'b0;
                        w_state = ST_IDLE;
                    end else if (wb_ack_i) begin
                        w_wb_v   = 1'b0;
                        w_wb_exc = 1'b0;
                        w_state  = ST_IDLE;
                    end
                end
                default: begin
                    w_go    = 1'b0;
                    w_wb_v  = 1'b0;
                    w_state = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_go     <= 1'b0;
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_wb_v   <= 1'b0;
            r_wb_tag <= '0;
            r_wb_res <= '0;
            r_wb_exc <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_cnt    <= w_cnt;
            r_go     <= w_go;
            r_op     <= w_op;
            r_a      <= w_a;
            r_b      <= w_b;
            r_wb_v   <= w_wb_v;
            r_wb_tag <= w_wb_tag;
            r_wb_res <= w_wb_res;
            r_wb_exc <= w_wb_exc;
        end
    end

    assign issue_rdy_o = (r_state == ST_IDLE);
    assign fu_go_o     = r_go;
    assign fu_op_o     = r_op;
    assign fu_a_o      = r_a;
    assign fu_b_o      = r_b;
    assign wb_v_o      = r_wb_v;
    assign wb_tag_o    = r_wb_tag;
    assign wb_res_o    = r_wb_res;
    assign wb_exc_o    = r_wb_exc;

endmodule

// File: tb/tb_fu_issue_ctrl.sv
// Bench for fu_issue_ctrl: a ready_gen-style delay line plus a toy ALU stand in for the
// functional unit; each operation is predicted at transaction level and compared.
module tb_fu_issue_ctrl;

    localparam int DW   = 52;
    localparam int TAGW = 4;
    localparam int TMO  = 8;
    localparam int TMOW = 4;
    localparam int S    = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            ce_i = 1'b1;
    logic            issue_v = 1'b0;
    logic            issue_rdy;
    logic [TAGW-1:0] issue_tag = '0;
    logic [3:0]      issue_op = '0;
    logic [DW-1:0]   issue_a = '0;
    logic [DW-1:0]   issue_b = '0;
    logic            fu_go;
    logic [3:0]      fu_op;
    logic [DW-1:0]   fu_a;
    logic [DW-1:0]   fu_b;
    logic            fu_done;
    logic [DW-1:0]   fu_res;
    logic            wb_v;
    logic [TAGW-1:0] wb_tag;
    logic [DW-1:0]   wb_res;
    logic            wb_exc;
    logic            wb_ack = 1'b0;
    logic            flush = 1'b0;
    logic            unit_en = 1'b1;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] calc(input logic [3:0] op, input logic [DW-1:0] a,
                                           input logic [DW-1:0] b);
        case (op[1:0])
            2'd0:    return a + b;
            2'd1:    return a ^ b;
            2'd2:    return a - b;
            default: return a & b;
        endcase
    endfunction

    // Delay line: output rises S+1 enabled edges after go, drops one edge after go falls
    logic [S-1:0] rg_sr;
    logic         rg_o;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rg_sr <= '0;
            rg_o  <= 1'b0;
        end else if (ce_i) begin
            rg_sr <= fu_go ? {rg_sr[S-2:0], 1'b1} : '0;
            rg_o  <= fu_go & rg_sr[S-1];
        end
    end
    assign fu_done = rg_o & unit_en;
    assign fu_res  = rg_o ? calc(fu_op, fu_a, fu_b) : {DW{1'b1}};

    fu_issue_ctrl #(.DW(DW), .TAGW(TAGW), .TMO(TMO), .TMOW(TMOW)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .ce_i       (ce_i),
        .issue_v_i  (issue_v),
        .issue_rdy_o(issue_rdy),
        .issue_tag_i(issue_tag),
        .issue_op_i (issue_op),
        .issue_a_i  (issue_a),
        .issue_b_i  (issue_b),
        .fu_go_o    (fu_go),
        .fu_op_o    (fu_op),
        .fu_a_o     (fu_a),
        .fu_b_o     (fu_b),
        .fu_done_i  (fu_done),
        .fu_res_i   (fu_res),
        .wb_v_o     (wb_v),
        .wb_tag_o   (wb_tag),
        .wb_res_o   (wb_res),
        .wb_exc_o   (wb_exc),
        .wb_ack_i   (wb_ack),
        .flush_i    (flush)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ce_mode: 0 always on, 1 random, 2 off for four cycles mid-RUN.
    // flush_at: loop index of the RUN flush edge, -1 for none.
    task automatic do_op(input logic [TAGW-1:0] tag, input logic [3:0] op,
                         input logic [DW-1:0] a, input logic [DW-1:0] b, input int ce_mode,
                         input int flush_at, input int ack_wait, input bit flush_idle,
                         input bit wb_flush, input string nm);
        bit exp_exc;
        bit seen;
        int en_edges;
        int cycles;
        int exp_lat;
        logic [DW-1:0] exp_res;
        exp_exc  = !unit_en;
        seen     = 1'b0;
        en_edges = 0;
        cycles   = 0;
        exp_lat  = exp_exc ? TMO : S + 2;
        exp_res  = exp_exc ? '0 : calc(op, a, b);

        chk({nm, "_rdy_pre"}, issue_rdy, 1);
        issue_v = 1'b1; issue_tag = tag; issue_op = op; issue_a = a; issue_b = b;
        flush = flush_idle; ce_i = 1'b1;
        tick();
        issue_v = 1'b0; flush = 1'b0;
        chk({nm, "_go"}, fu_go, 1);
        chk({nm, "_rdy_run"}, issue_rdy, 0);
        chk({nm, "_fu_a"}, fu_a, a);
        chk({nm, "_fu_b"}, fu_b, b);
        chk({nm, "_fu_op"}, fu_op, op);

        for (int k = 0; k < 60 && !seen; k++) begin
            if (k == flush_at) begin
                ce_i = 1'b1; flush = 1'b1;
            end else if (ce_mode == 1) ce_i = ($urandom_range(3) != 0);
            else if (ce_mode == 2) ce_i = !(k >= 2 && k < 6);
            else ce_i = 1'b1;
            tick();
            flush = 1'b0;
            cycles++;
            if (ce_i) en_edges++;
            if (k == flush_at) begin
                ce_i = 1'b1;
                chk({nm, "_flush_go"}, fu_go, 0);
                chk({nm, "_flush_rdy"}, issue_rdy, 1);
                chk({nm, "_flush_wbv"}, wb_v, 0);
                tick();
                chk({nm, "_flush_wbv2"}, wb_v, 0);
                return;
            end
            if (ce_mode == 2 && k >= 2 && k < 6) chk({nm, "_frozen_go"}, fu_go, 1);
            seen = wb_v;
        end
        ce_i = 1'b1;
        chk({nm, "_wbv_seen"}, seen, 1);
        if (!seen) return;
        chk({nm, "_lat"}, 64'(en_edges), 64'(exp_lat));
        if (ce_mode == 2) chk({nm, "_lat_cyc"}, 64'(cycles), 64'(exp_lat + 4));
        chk({nm, "_tag"}, wb_tag, tag);
        chk({nm, "_res"}, wb_res, exp_res);
        chk({nm, "_exc"}, wb_exc, exp_exc);
        chk({nm, "_go_wb"}, fu_go, 0);

        for (int k = 0; k < ack_wait; k++) begin
            ce_i = (ce_mode == 1) ? 1'($urandom_range(1)) : 1'b1;
            tick();
            chk({nm, "_hold_v"}, wb_v, 1);
            chk({nm, "_hold_tag"}, wb_tag, tag);
            chk({nm, "_hold_res"}, wb_res, exp_res);
            chk({nm, "_hold_exc"}, wb_exc, exp_exc);
        end
        ce_i = 1'b1; wb_ack = 1'b1; flush = wb_flush;
        tick();
        wb_ack = 1'b0; flush = 1'b0;
        chk({nm, "_ack_v"}, wb_v, 0);
        chk({nm, "_ack_rdy"}, issue_rdy, 1);
        if (!wb_flush) chk({nm, "_ack_exc"}, wb_exc, 0);
    endtask

    initial begin
        logic [DW-1:0] ra;
        logic [DW-1:0] rb;
        int fa;

        tick();
        tick();
        chk("rst_rdy", issue_rdy, 1);
        chk("rst_go", fu_go, 0);
        chk("rst_wbv", wb_v, 0);
        chk("rst_tag", wb_tag, 0);
        chk("rst_res", wb_res, 0);
        chk("rst_exc", wb_exc, 0);
        chk("rst_fu_a", fu_a, 0);
        rst = 1'b0;
        tick();

        do_op(4'd5, 4'd0, 52'd3, 52'd4, 0, -1, 10, 1'b0, 1'b0, "basic");
        do_op(4'd9, 4'd1, 52'h123, 52'h456, 0, 1, 0, 1'b0, 1'b0, "flush_run");
        do_op(4'd10, 4'd2, 52'd100, 52'd1, 0, -1, 0, 1'b0, 1'b0, "after_flush");
        do_op(4'd2, 4'd3, 52'hff0f, 52'h0ff0, 0, -1, 1, 1'b1, 1'b0, "flush_idle");
        do_op(4'd11, 4'd0, 52'd7, 52'd8, 0, -1, 2, 1'b0, 1'b1, "flush_wb");
        unit_en = 1'b0;
        do_op(4'd6, 4'd0, 52'd1, 52'd1, 0, -1, 2, 1'b0, 1'b0, "timeout");
        unit_en = 1'b1;
        do_op(4'd7, 4'd1, 52'habc, 52'h111, 2, -1, 0, 1'b0, 1'b0, "ce_gap");

        // Asynchronous reset landing between edges while a writeback is pending
        issue_v = 1'b1; issue_tag = 4'd3; issue_op = 4'd0; issue_a = 52'd20; issue_b = 52'd22;
        tick();
        issue_v = 1'b0;
        repeat (S + 2) tick();
        chk("mrst_pre_wbv", wb_v, 1);
        #2 rst = 1'b1;
        #1;
        chk("mrst_wbv", wb_v, 0);
        chk("mrst_rdy", issue_rdy, 1);
        chk("mrst_go", fu_go, 0);
        chk("mrst_tag", wb_tag, 0);
        chk("mrst_res", wb_res, 0);
        tick();
        rst = 1'b0;
        tick();

        for (int i = 0; i < 30; i++) begin
            ra = DW'({$urandom(), $urandom()});
            rb = DW'({$urandom(), $urandom()});
            unit_en = ($urandom_range(5) != 0);
            fa = ($urandom_range(4) == 0) ? int'($urandom_range(S)) : -1;
            do_op(4'($urandom()), 4'($urandom()), ra, rb, unit_en ? int'($urandom_range(1)) : 0,
                  fa, int'($urandom_range(5)), 1'($urandom_range(1)),
                  ($urandom_range(4) == 0), "rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
